alu_seq: RTL and testbench

- Multi-byte sequencer around the 8-bit combinational `alu`, instantiated once internally.
- Accepts a command (op, byte count, carry-in), then streams operand byte pairs through the ALU one per cycle.
- Chains carry between bytes by promoting base ops to their carry variants, and streams result bytes out with valid/ready.
- Publishes the final carry and an aggregate zero flag once the last result byte leaves.

---
 rtl/alu_seq.sv | 261 ++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// alu_seq : streams cmd_len+1 operand byte pairs through one 8-bit ALU,
//           chaining carry between bytes. Optional macro: ALU_SEQ_OVF_EN.
// Rev 1.0
// ============================================================================

module alu (
  input  logic [3:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] c,
  output logic       carry_out,
  output logic       zero
);
  // Subtracts report borrow as carry_out=1; compares return their flag in c[0] and carry_out.
  always_comb begin
    c         = '0;
    carry_out = 1'b0;
    case (op)
      4'd0:  {carry_out, c} = {1'b0, a} + {1'b0, b};
      4'd1:  {carry_out, c} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      4'd2:  {carry_out, c} = {1'b0, a} - {1'b0, b};
      4'd3:  {carry_out, c} = {1'b0, a} - {1'b0, b} - {8'd0, cin};
      4'd4:  c = a | b;
      4'd5:  c = a & b;
      4'd6:  c = ~a;
      4'd7:  c = a ^ b;
      4'd8:  c = a;
      4'd9:  begin carry_out = (a == b); c = {7'd0, a == b}; end
      4'd10: begin carry_out = (a < b);  c = {7'd0, a < b};  end
      4'd11: begin
        carry_out = ($signed(a) < $signed(b));
        c         = {7'd0, $signed(a) < $signed(b)};
      end
      4'd12, 4'd13: {carry_out, c} = {a, 1'b0};
      4'd14: {carry_out, c} = {a, cin};
      default: {c, carry_out} = {cin, a};
    endcase
  end

  assign zero = (c == 8'd0);
endmodule

module alu_seq #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_cin,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_c,
  output logic             out_last,
  output logic             done,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             busy
`ifdef ALU_SEQ_OVF_EN
  , output logic           ovf_flag
`endif
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             cin_q, cin_d;
  logic             first_q, first_d;
  logic             zacc_q, zacc_d;
  logic             chain_q, chain_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_c_q, out_c_d;
  logic             out_last_q, out_last_d;
  logic             done_q, done_d;
  logic             carry_flag_q, carry_flag_d;
  logic             zero_flag_q, zero_flag_d;

  logic [3:0] op_eff;
  logic       cin_eff;
  logic [7:0] alu_c;
  logic       alu_co;
  logic       alu_zero;
  logic       in_ready_w;
  logic       accept;
  logic       out_xfer;

  alu u_alu (
    .op        (op_eff),
    .a         (in_a),
    .b         (in_b),
    .cin       (cin_eff),
    .c         (alu_c),
    .carry_out (alu_co),
    .zero      (alu_zero)
  );

`ifdef ALU_SEQ_OVF_EN
  logic ovf_last_q, ovf_last_d;
  logic ovf_flag_q, ovf_flag_d;
  logic ovf_calc;

  always_comb begin
    ovf_calc = 1'b0;
    case (op_eff)
      4'd0, 4'd1: ovf_calc = (in_a[7] == in_b[7]) && (alu_c[7] != in_a[7]);
      4'd2, 4'd3: ovf_calc = (in_a[7] != in_b[7]) && (alu_c[7] != in_a[7]);
      default:    ovf_calc = 1'b0;
    endcase
  end

  assign ovf_flag = ovf_flag_q;
`endif

  // Bytes after the first switch to carry-consuming variants of the base op.
  always_comb begin
    op_eff = op_q;
    if (!first_q) begin
      case (op_q)
        4'd0:         op_eff = 4'd1;
        4'd2:         op_eff = 4'd3;
        4'd12, 4'd13: op_eff = 4'd14;
        default:      op_eff = op_q;
      endcase
    end
  end

  assign cin_eff    = first_q ? cin_q : chain_q;
  assign out_xfer   = out_valid_q & out_ready;
  assign in_ready_w = (state_q == S_RUN) & (~out_valid_q | out_ready);
  assign accept     = in_valid & in_ready_w;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rem_d        = rem_q;
    cin_d        = cin_q;
    first_d      = first_q;
    zacc_d       = zacc_q;
    chain_d      = chain_q;
    out_valid_d  = out_valid_q;
    out_c_d      = out_c_q;
    out_last_d   = out_last_q;
    done_d       = 1'b0;
    carry_flag_d = carry_flag_q;
    zero_flag_d  = zero_flag_q;
`ifdef ALU_SEQ_OVF_EN
    ovf_last_d   = ovf_last_q;
    ovf_flag_d   = ovf_flag_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          rem_d   = cmd_len;
          cin_d   = cmd_cin;
          first_d = 1'b1;
          zacc_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (out_xfer) out_valid_d = 1'b0;
        if (accept) begin
          out_c_d     = alu_c;
          out_last_d  = (rem_q == '0);
          out_valid_d = 1'b1;
          chain_d     = alu_co;
          zacc_d      = zacc_q & alu_zero;
          first_d     = 1'b0;
          if (rem_q == '0) begin
            state_d = S_FLUSH;
`ifdef ALU_SEQ_OVF_EN
            ovf_last_d = ovf_calc;
`endif
          end else begin
            rem_d = rem_q - LEN_W'(1);
          end
        end
      end
      S_FLUSH: begin
        if (out_xfer) begin
          out_valid_d  = 1'b0;
          carry_flag_d = chain_q;
          zero_flag_d  = zacc_q;
          done_d       = 1'b1;
          state_d      = S_IDLE;
`ifdef ALU_SEQ_OVF_EN
          ovf_flag_d   = ovf_last_q;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      rem_q        <= '0;
      cin_q        <= 1'b0;
      first_q      <= 1'b0;
      zacc_q       <= 1'b0;
      chain_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_c_q      <= '0;
      out_last_q   <= 1'b0;
      done_q       <= 1'b0;
      carry_flag_q <= 1'b0;
      zero_flag_q  <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      ovf_last_q   <= 1'b0;
      ovf_flag_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rem_q        <= rem_d;
      cin_q        <= cin_d;
      first_q      <= first_d;
      zacc_q       <= zacc_d;
      chain_q      <= chain_d;
      out_valid_q  <= out_valid_d;
      out_c_q      <= out_c_d;
      out_last_q   <= out_last_d;
      done_q       <= done_d;
      carry_flag_q <= carry_flag_d;
      zero_flag_q  <= zero_flag_d;
`ifdef ALU_SEQ_OVF_EN
      ovf_last_q   <= ovf_last_d;
      ovf_flag_q   <= ovf_flag_d;
`endif
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign in_ready   = in_ready_w;
  assign out_valid  = out_valid_q;
  assign out_c      = out_c_q;
  assign out_last   = out_last_q;
  assign done       = done_q;
  assign carry_flag = carry_flag_q;
  assign zero_flag  = zero_flag_q;
endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// tb_alu_seq : scoreboard bench for alu_seq; expected bytes come from a local ALU model.
module tb_alu_seq;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [3:0]       cmd_op = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             cmd_cin = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_a = '0;
  logic [7:0]       in_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [7:0]       out_c;
  logic             out_last;
  logic             done;
  logic             carry_flag;
  logic             zero_flag;
  logic             busy;
`ifdef ALU_SEQ_OVF_EN
  logic             ovf_flag;
`endif

  alu_seq #(.LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_len    (cmd_len),
    .cmd_cin    (cmd_cin),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_c      (out_c),
    .out_last   (out_last),
    .done       (done),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .busy       (busy)
`ifdef ALU_SEQ_OVF_EN
    , .ovf_flag (ovf_flag)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  logic [8:0] sb_q[$];

  logic [3:0]       m_op;
  logic [LEN_W-1:0] m_rem;
  logic             m_cin, m_first, m_chain, m_zacc, m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] promote(input logic [3:0] op, input logic first);
    if (first) return op;
    case (op)
      4'd0:         return 4'd1;
      4'd2:         return 4'd3;
      4'd12, 4'd13: return 4'd14;
      default:      return op;
    endcase
  endfunction

  // Returns {carry, byte}, computed with integer arithmetic.
  function automatic logic [8:0] ref_alu(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic ci);
    int ia, ib, r, ic;
    logic co;
    ia = int'(a); ib = int'(b); ic = ci ? 1 : 0; r = 0; co = 1'b0;
    case (op)
      4'd0:  r = ia + ib;
      4'd1:  r = ia + ib + ic;
      4'd2:  r = ia - ib;
      4'd3:  r = ia - ib - ic;
      4'd4:  r = int'(a | b);
      4'd5:  r = int'(a & b);
      4'd6:  r = 255 - ia;
      4'd7:  r = int'(a ^ b);
      4'd8:  r = ia;
      4'd9:  r = (ia == ib) ? 1 : 0;
      4'd10: r = (ia < ib) ? 1 : 0;
      4'd11: r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd12, 4'd13: r = ia * 2;
      4'd14: r = ia * 2 + ic;
      default: r = ic * 128 + ia / 2;
    endcase
    if (op <= 4'd3 || (op >= 4'd12 && op <= 4'd14)) co = (r < 0) || (r > 255);
    else if (op >= 4'd9 && op <= 4'd11)            co = (r == 1);
    else if (op == 4'd15)                          co = a[0];
    return {co, r[7:0]};
  endfunction

  task automatic push_expect(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] eff;
    logic [8:0] res;
    logic       last;
    eff  = promote(m_op, m_first);
    res  = ref_alu(eff, a, b, m_first ? m_cin : m_chain);
    last = (m_rem == '0);
    sb_q.push_back({last, res[7:0]});
    m_chain = res[8];
    m_zacc  = m_zacc & (res[7:0] == 8'd0);
    if (last) begin
      if (eff == 4'd0 || eff == 4'd1)      m_ovf = (a[7] == b[7]) && (res[7] != a[7]);
      else if (eff == 4'd2 || eff == 4'd3) m_ovf = (a[7] != b[7]) && (res[7] != a[7]);
      else                                 m_ovf = 1'b0;
    end else begin
      m_rem = m_rem - 1'b1;
    end
    m_first = 1'b0;
  endtask

  // All driver tasks are entered just after a rising edge.
  task automatic send_cmd(input logic [3:0] op, input logic [LEN_W-1:0] len, input logic ci);
    int i;
    cmd_op = op; cmd_len = len; cmd_cin = ci; cmd_valid = 1'b1;
    m_op = op; m_rem = len; m_cin = ci; m_first = 1'b1; m_zacc = 1'b1; m_ovf = 1'b0;
    done_cnt = 0;
    @(negedge clk);
    for (i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, output int waits);
    in_a = a; in_b = b; in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (waits < 50) push_expect(a, b);
  endtask

  task automatic wait_done(input logic ec, input logic ez, input logic eo);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("carry_flag", 32'(carry_flag), 32'(ec));
    check("zero_flag", 32'(zero_flag), 32'(ez));
    check("busy_at_done", 32'(busy), 32'd0);
`ifdef ALU_SEQ_OVF_EN
    check("ovf_flag", 32'(ovf_flag), 32'(eo));
`else
    if (eo === 1'bx) $display("note: unknown ovf expectation");
`endif
    repeat (3) @(posedge clk);
    #1;
    check("done_once", 32'(done_cnt), 32'd1);
  endtask

  // Output monitor: pops the scoreboard on every transfer, checks stalled output stability.
  initial begin
    logic       hold_pending;
    logic [7:0] hold_c;
    logic [8:0] e;
    hold_pending = 1'b0;
    hold_c = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pending = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (hold_pending && out_valid) check("hold_c", 32'(out_c), 32'(hold_c));
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            check("sb_size", 32'(sb_q.size()), 32'd1);
          end else begin
            e = sb_q.pop_front();
            check("out_c", 32'(out_c), 32'(e[7:0]));
            check("out_last", 32'(out_last), 32'(e[8]));
          end
        end
        hold_pending = out_valid && !out_ready;
        hold_c = out_c;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, wsum;
    logic [3:0] rop;
    logic [LEN_W-1:0] rlen;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'({out_last, out_c}), 32'd0);
    check("rst_flags", 32'({done, carry_flag, zero_flag, busy}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 16-bit add
    send_cmd(4'd0, 4'd1, 1'b0);
    send_pair(8'hFF, 8'h01, w);
    send_pair(8'h12, 8'h00, w);
    wait_done(1'b0, 1'b0, 1'b0);

    // 16-bit sub with borrow
    send_cmd(4'd2, 4'd1, 1'b0);
    send_pair(8'h00, 8'h01, w);
    send_pair(8'h01, 8'h00, w);
    wait_done(1'b0, 1'b0, 1'b0);

    // Backpressure, with a stray command offered while busy
    send_cmd(4'd0, 4'd3, 1'b0);
    send_pair(8'h01, 8'hFF, w);
    out_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 4'd7;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    wsum = 0;
    send_pair(8'h00, 8'h00, w); wsum += w;
    send_pair(8'h80, 8'h80, w); wsum += w;
    send_pair(8'h7F, 8'h00, w); wsum += w;
    check("bp_rate_waits", 32'(wsum), 32'd0);
    wait_done(1'b0, 1'b0, 1'b1);

    // Zero aggregate
    send_cmd(4'd7, 4'd2, 1'b0);
    send_pair(8'h5A, 8'h5A, w);
    send_pair(8'h00, 8'h00, w);
    send_pair(8'hC3, 8'hC3, w);
    wait_done(1'b0, 1'b1, 1'b0);

    // Reset mid-operation
    send_cmd(4'd14, 4'd3, 1'b1);
    send_pair(8'h80, 8'h00, w);
    send_pair(8'h40, 8'h00, w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_flags", 32'({carry_flag, zero_flag}), 32'd0);
    @(posedge clk); #1;
    send_cmd(4'd12, 4'd0, 1'b0);
    send_pair(8'h81, 8'h00, w);
    wait_done(1'b1, 1'b0, 1'b0);

    // Signed overflow on a single byte
    send_cmd(4'd0, 4'd0, 1'b0);
    send_pair(8'h7F, 8'h01, w);
    wait_done(1'b0, 1'b0, 1'b1);

    // Random commands; the first uses the maximum length
    for (int k = 0; k < 6; k++) begin
      rop  = 4'($urandom_range(0, 15));
      rlen = (k == 0) ? 4'hF : 4'($urandom_range(0, 15));
      send_cmd(rop, rlen, 1'($urandom_range(0, 1)));
      for (int j = 0; j <= int'(rlen); j++)
        send_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), w);
      wait_done(m_chain, m_zacc, m_ovf);
    end

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
